// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   - ldr_state_e    : loader FSM state encoding (LDR_ST_*)
//   - IM_ADDR_W_DEF  : default instruction-memory word-address width
//   - WORD_W/BYTE_W  : instruction word and stream byte widths
//   - accepts_bytes(): states in which the loader raises byte_ready
package imem_loader_pkg;

    localparam int unsigned IM_ADDR_W_DEF = 10;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [2:0] {
        LDR_ST_LEN   = 3'd0,
        LDR_ST_DATA  = 3'd1,
        LDR_ST_WRITE = 3'd2,
        LDR_ST_CSUM  = 3'd3,
        LDR_ST_DONE  = 3'd4,
        LDR_ST_ERR   = 3'd5
    } ldr_state_e;

    // States that take a byte from the stream.
    function automatic logic accepts_bytes(input ldr_state_e st);
        return (st == LDR_ST_LEN) || (st == LDR_ST_DATA) || (st == LDR_ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// imem_loader_word_packer: packs four stream bytes MSB-first into a 32-bit word.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   byte_en_i    : a DATA byte transfers this cycle
//   byte_i       : byte value
//   word_o       : packed word (registered)
//   word_done_c  : combinational pulse when the 4th byte of a word transfers
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_c
);

    logic [1:0]        idx_q;
    logic [1:0]        idx_d;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    // Byte 0 ends up in [31:24] after four left shifts.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (byte_en_i) begin
            idx_d  = idx_q + 2'd1;
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_done_c = byte_en_i && (idx_q == 2'd3);
    assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (4-byte big-endian word count, then that
// many big-endian 32-bit words), writes the words to instruction memory from
// address 0 upward, then raises cpu_run.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   byte_valid/byte_data    : byte stream input
//   byte_ready              : loader accepts a byte this cycle
//   im_we/im_addr/im_wdata  : instruction-memory write port
//   cpu_run                 : load complete
//   load_err                : load aborted (count too large or checksum mismatch)
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IM_ADDR_W = IM_ADDR_W_DEF
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 byte_valid,
    input  logic [BYTE_W-1:0]    byte_data,
    output logic                 byte_ready,
    output logic                 im_we,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0]    im_wdata,
    output logic                 cpu_run,
    output logic                 load_err
);

    localparam int unsigned WCNT_W   = IM_ADDR_W + 1;
    localparam logic [32:0] CAPACITY = 33'(1) << IM_ADDR_W;

    ldr_state_e        state_q;
    ldr_state_e        state_d;
    ldr_state_e        after_last_c;
    logic [31:0]       count_q;
    logic [31:0]       count_d;
    logic [1:0]        len_idx_q;
    logic [1:0]        len_idx_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic              ready_q;
    logic              we_q;
    logic              run_q;
    logic              err_q;
    logic              hs_c;
    logic              pack_en_c;
    logic              word_done_c;
    logic [WORD_W-1:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q;
    logic [BYTE_W-1:0] xor_d;
    assign after_last_c = LDR_ST_CSUM;
`else
    assign after_last_c = LDR_ST_DONE;
`endif

    assign hs_c      = byte_valid && ready_q;
    assign pack_en_c = hs_c && (state_q == LDR_ST_DATA);

    imem_loader_word_packer u_word_packer (
        .clk         (clk),
        .reset       (reset),
        .byte_en_i   (pack_en_c),
        .byte_i      (byte_data),
        .word_o      (word),
        .word_done_c (word_done_c)
    );

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_idx_d = len_idx_q;
        wcnt_d    = wcnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            LDR_ST_LEN: begin
                if (hs_c) begin
                    count_d   = {count_q[23:0], byte_data};
                    len_idx_d = len_idx_q + 2'd1;
                    if (len_idx_q == 2'd3) begin
                        if (count_d == 32'd0) begin
                            state_d = after_last_c;
                        end else if ({1'b0, count_d} > CAPACITY) begin
                            state_d = LDR_ST_ERR;
                        end else begin
                            state_d = LDR_ST_DATA;
                        end
                    end
                end
            end
            LDR_ST_DATA: begin
                if (hs_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ byte_data;
`endif
                    if (word_done_c) begin
                        state_d = LDR_ST_WRITE;
                    end
                end
            end
            LDR_ST_WRITE: begin
                wcnt_d  = wcnt_q + WCNT_W'(1);
                state_d = (32'(wcnt_d) == count_q) ? after_last_c : LDR_ST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LDR_ST_CSUM: begin
                if (hs_c) begin
                    state_d = (byte_data == xor_q) ? LDR_ST_DONE : LDR_ST_ERR;
                end
            end
`endif
            LDR_ST_DONE: state_d = LDR_ST_DONE;
            LDR_ST_ERR:  state_d = LDR_ST_ERR;
            default:     state_d = LDR_ST_ERR;
        endcase
    end

    // State and registered outputs; outputs follow state_d so they align with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LDR_ST_LEN;
            count_q   <= '0;
            len_idx_q <= '0;
            wcnt_q    <= '0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_idx_q <= len_idx_d;
            wcnt_q    <= wcnt_d;
            ready_q   <= accepts_bytes(state_d);
            we_q      <= (state_d == LDR_ST_WRITE);
            run_q     <= (state_d == LDR_ST_DONE);
            err_q     <= (state_d == LDR_ST_ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign byte_ready = ready_q;
    assign im_we      = we_q;
    assign im_addr    = wcnt_q[IM_ADDR_W-1:0];
    assign im_wdata   = word;
    assign cpu_run    = run_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader.
module tb_imem_loader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_run;
    logic          load_err;

    always #5 clk = ~clk;

    imem_loader #(.IM_ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_run    (cpu_run),
        .load_err   (load_err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  run_cyc = -1;
    int  err_cyc = -1;
    int  we_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every write and records terminal events.
    always @(negedge clk) begin
        if (reset) begin
            run_cyc = -1;
            err_cyc = -1;
            we_cnt  = 0;
            exp_q.delete();
        end else begin
            if (im_we) begin
                wr_t e;
                we_cnt++;
                chk("write_ready_low", 64'(byte_ready), 64'(0));
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(im_addr), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 64'(im_addr), 64'(e.addr));
                    chk("write_data", 64'(im_wdata), 64'(e.data));
                    chk("write_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (cpu_run && run_cyc < 0) run_cyc = cyc;
            if (load_err && err_cyc < 0) err_cyc = cyc;
            if (cpu_run || load_err) chk("terminal_ready_low", 64'(byte_ready), 64'(0));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_byte_ready", 64'(byte_ready), 64'(1));
        chk("rst_im_we",      64'(im_we),      64'(0));
        chk("rst_im_addr",    64'(im_addr),    64'(0));
        chk("rst_im_wdata",   64'(im_wdata),   64'(0));
        chk("rst_cpu_run",    64'(cpu_run),    64'(0));
        chk("rst_load_err",   64'(load_err),   64'(0));
    endtask

    // Offers one byte until it is accepted; hs_cyc is the cycle of the transfer.
    task automatic send_byte(input logic [7:0] b, input bit rnd, output int hs_cyc, output bit ok);
        ok     = 1'b0;
        hs_cyc = -1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (rnd && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                if (byte_ready) begin
                    ok     = 1'b1;
                    hs_cyc = cyc;
                end
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
        end else begin
            byte_valid = 1'b0;
            chk("byte_accept_timeout", 64'(0), 64'(1));
        end
    endtask

    // Reference: count > 2^AW aborts one cycle after the 4th count byte; otherwise
    // word k goes to address k one cycle after its last byte, and the load
    // completes one cycle after the last write (or the last count byte / checksum byte).
    task automatic run_load(input string nm, input logic [31:0] count, input logic [31:0] w[$],
                            input bit rnd, input bit bad_csum);
        int          hs;
        bit          ok;
        int          exp_run;
        int          exp_err;
        int          n_wr;
        logic [7:0]  x;
        logic [31:0] wd;
        logic [7:0]  b;
        exp_run = -1;
        exp_err = -1;
        n_wr    = 0;
        x       = 8'h00;
        hs      = -1;
        for (int i = 0; i < 4; i++) begin
            b = count[31-8*i -: 8];
            send_byte(b, rnd, hs, ok);
            if (!ok) return;
        end
        if (64'(count) > (64'(1) << AW)) begin
            exp_err = hs + 1;
        end else begin
            for (int k = 0; k < int'(count); k++) begin
                wd = w[k];
                for (int i = 0; i < 4; i++) begin
                    b = wd[31-8*i -: 8];
                    send_byte(b, rnd, hs, ok);
                    if (!ok) return;
                    x = x ^ b;
                end
                exp_q.push_back('{addr: AW'(k), data: wd, cyc: hs + 1});
                n_wr++;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(bad_csum ? (x ^ 8'h01) : x, rnd, hs, ok);
            if (!ok) return;
            if (bad_csum) exp_err = hs + 1;
            else          exp_run = hs + 1;
`else
            exp_run = (count == 32'd0) ? hs + 1 : hs + 2;
`endif
        end
        for (int i = 0; i < 40 && run_cyc < 0 && err_cyc < 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({nm, "_cpu_run"},   64'(cpu_run),       64'(exp_run >= 0));
        chk({nm, "_load_err"},  64'(load_err),      64'(exp_err >= 0));
        chk({nm, "_run_cycle"}, 64'(run_cyc),       64'(exp_run));
        chk({nm, "_err_cycle"}, 64'(err_cyc),       64'(exp_err));
        chk({nm, "_n_writes"},  64'(we_cnt),        64'(n_wr));
        chk({nm, "_sb_empty"},  64'(exp_q.size()),  64'(0));
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] wd;
        logic [7:0]  b;
        int          hs;
        int          cnt;
        bit          ok;

        do_reset();
        w = '{32'h3C01_1234, 32'h3421_5678};
        run_load("plan2", 32'd2, w, 1'b0, 1'b0);

        do_reset();
        run_load("plan2_rnd", 32'd2, w, 1'b1, 1'b0);

        do_reset();
        w.delete();
        run_load("count0", 32'd0, w, 1'b1, 1'b0);

        do_reset();
        run_load("over_cap", 32'h0000_0401, w, 1'b0, 1'b0);

        do_reset();
        w.delete();
        for (int k = 0; k < 1024; k++) w.push_back($urandom);
        run_load("full_cap", 32'h0000_0400, w, 1'b1, 1'b0);

        // Reset after two bytes of the second word.
        do_reset();
        w = '{32'h1122_3344, 32'h5566_7788};
        for (int i = 0; i < 4; i++) begin
            b = 8'(i == 3 ? 2 : 0);
            send_byte(b, 1'b1, hs, ok);
        end
        wd = w[0];
        for (int i = 0; i < 4; i++) begin
            b = wd[31-8*i -: 8];
            send_byte(b, 1'b1, hs, ok);
        end
        exp_q.push_back('{addr: AW'(0), data: wd, cyc: hs + 1});
        wd = w[1];
        for (int i = 0; i < 2; i++) begin
            b = wd[31-8*i -: 8];
            send_byte(b, 1'b1, hs, ok);
        end
        repeat (3) @(negedge clk);
        chk("midload_writes", 64'(we_cnt), 64'(1));
        chk("midload_sb_empty", 64'(exp_q.size()), 64'(0));
        do_reset();
        w = '{32'hAABB_CCDD};
        run_load("reload", 32'd1, w, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            cnt = $urandom_range(1, 6);
            w.delete();
            for (int k = 0; k < cnt; k++) w.push_back($urandom);
            run_load("random", 32'(cnt), w, 1'b1, 1'b0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        w = '{32'h0102_0408};
        run_load("csum_good", 32'd1, w, 1'b0, 1'b0);
        do_reset();
        run_load("csum_bad", 32'd1, w, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
